// File: rtl/forwarding_register_file_pkg.sv
// ----------------------------------------------------------------------------
// forwarding_register_file_pkg
//
// Purpose:
//   Shared definitions for the decode-stage forwarding register file. It holds
//   the default widths, the in-flight destination record carried down the
//   tracked stages, and the encoding of the "read from the array" select.
//
// Contents:
//   DEFAULT_DATA_WIDTH / DEFAULT_ADDR_WIDTH : default register/address widths
//   RECORD_ADDR_WIDTH                       : address field width in a record
//   SEL_ARRAY                               : forward select meaning "array"
//   stage_record_t                          : {valid, address, isLoad}
//   EMPTY_RECORD                            : an invalid record (bubble)
//   recordMatches()                         : valid record with equal address
// ----------------------------------------------------------------------------
package forwarding_register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    // Records carry a fixed-width address field so the struct can live in the
    // package; users zero-extend their ADDR_WIDTH address into it, which
    // limits ADDR_WIDTH to at most this many bits.
    localparam int RECORD_ADDR_WIDTH = 8;

    localparam int SEL_ARRAY = 0;

    typedef struct packed {
        logic                         valid;
        logic [RECORD_ADDR_WIDTH-1:0] address;
        logic                         isLoad;
    } stage_record_t;

    localparam stage_record_t EMPTY_RECORD = '{valid: 1'b0, address: '0, isLoad: 1'b0};

    function automatic logic recordMatches(
        input stage_record_t                record,
        input logic [RECORD_ADDR_WIDTH-1:0] address
    );
        return record.valid && (record.address == address);
    endfunction

endpackage

// File: rtl/forwarding_register_file_regfile_array.sv
// ----------------------------------------------------------------------------
// regfile_array
//
// Purpose:
//   2**ADDR_WIDTH x DATA_WIDTH register array with READ_PORTS asynchronous
//   read ports and a single synchronous write port. Register 0 always reads
//   as zero and is never written. A synchronous reset clears every entry.
//
// Ports:
//   clock        in   system clock
//   reset        in   synchronous active-high clear of all registers
//   readAddress  in   READ_PORTS*ADDR_WIDTH, per-port read address
//   readData     out  READ_PORTS*DATA_WIDTH, per-port read value
//   writeEnable  in   write writeData to writeAddress at the clock edge
//   writeAddress in   ADDR_WIDTH, destination register
//   writeData    in   DATA_WIDTH, value to write
// ----------------------------------------------------------------------------
module regfile_array
    import forwarding_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int READ_PORTS = 2
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    input  logic                             writeEnable,
    input  logic [ADDR_WIDTH-1:0]            writeAddress,
    input  logic [DATA_WIDTH-1:0]            writeData
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_registers [NUM_REGS];

    // Storage update: reset clears everything; writes to register 0 are
    // dropped so it stays zero no matter what the pipeline retires.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_registers[i] <= '0;
            end
        end else if (writeEnable && (writeAddress != '0)) begin
            r_registers[writeAddress] <= writeData;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_address;
        assign w_address = readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
        assign readData[p*DATA_WIDTH +: DATA_WIDTH] =
            (w_address == '0) ? '0 : r_registers[w_address];
    end

endmodule

// File: rtl/forwarding_register_file.sv
// ----------------------------------------------------------------------------
// forwarding_register_file
//
// Purpose:
//   Decode-stage register file with operand forwarding and load-use stall
//   generation. A shift pipeline of destination records mirrors the
//   instructions in flight in stages 1 (EX) .. PIPE_DEPTH (WB). Each read
//   port takes its operand from the youngest matching stage, or from the
//   array when nothing in flight targets that register. A record leaving the
//   last stage writes stageData of that stage into the array.
//
// Ports:
//   clock          in   system clock
//   reset          in   synchronous active-high reset
//   readAddress    in   READ_PORTS*ADDR_WIDTH, per-port source register
//   readEnable     in   READ_PORTS, per-port "operand is used" (gates stall)
//   readData       out  READ_PORTS*DATA_WIDTH, per-port forwarded operand
//   forwardSelect  out  READ_PORTS*SEL_WIDTH, 0 = array, k = stage k
//   issueValid     in   decode presents an instruction
//   issueWrites    in   that instruction writes a register
//   issueAddress   in   ADDR_WIDTH, its destination register
//   issueIsLoad    in   its result is produced by a load
//   stageData      in   PIPE_DEPTH*DATA_WIDTH, result held at stage k
//                       (slice k-1)
//   shouldStall    out  hold PC/IF-ID and inject a bubble
//   stallCount     out  32, saturating count of stalled cycles
// ----------------------------------------------------------------------------
module forwarding_register_file
    import forwarding_register_file_pkg::*;
#(
    parameter int DATA_WIDTH       = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH       = DEFAULT_ADDR_WIDTH,
    parameter int READ_PORTS       = 2,
    parameter int PIPE_DEPTH       = 3,
    parameter int LOAD_READY_STAGE = 2,
    parameter int SEL_WIDTH        = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [READ_PORTS*ADDR_WIDTH-1:0] readAddress,
    input  logic [READ_PORTS-1:0]            readEnable,
    output logic [READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [READ_PORTS*SEL_WIDTH-1:0]  forwardSelect,
    input  logic                             issueValid,
    input  logic                             issueWrites,
    input  logic [ADDR_WIDTH-1:0]            issueAddress,
    input  logic                             issueIsLoad,
    input  logic [PIPE_DEPTH*DATA_WIDTH-1:0] stageData,
    output logic                             shouldStall,
    output logic [31:0]                      stallCount
);

    stage_record_t r_stages [1:PIPE_DEPTH];
    logic [31:0]   r_stallCount;

    stage_record_t                    w_issueRecord;
    logic                             w_stall;
    logic [READ_PORTS-1:0]            w_loadHazard;
    logic [READ_PORTS*DATA_WIDTH-1:0] w_arrayData;
    logic                             w_writeEnable;
    logic [ADDR_WIDTH-1:0]            w_writeAddress;
    logic [DATA_WIDTH-1:0]            w_writeData;

    // Retirement: the oldest tracked stage writes back through the array's
    // write port. During reset the array clear takes priority, so pending
    // records are discarded without ever reaching the array.
    assign w_writeEnable  = r_stages[PIPE_DEPTH].valid;
    assign w_writeAddress = r_stages[PIPE_DEPTH].address[ADDR_WIDTH-1:0];
    assign w_writeData    = stageData[(PIPE_DEPTH-1)*DATA_WIDTH +: DATA_WIDTH];

    regfile_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .READ_PORTS (READ_PORTS)
    ) u_array (
        .clock        (clock),
        .reset        (reset),
        .readAddress  (readAddress),
        .readData     (w_arrayData),
        .writeEnable  (w_writeEnable),
        .writeAddress (w_writeAddress),
        .writeData    (w_writeData)
    );

    // The record entering stage 1. A stall turns it into a bubble, and a
    // write to register 0 is never tracked since nothing can depend on it.
    always_comb begin
        w_issueRecord         = EMPTY_RECORD;
        w_issueRecord.valid   = issueValid && issueWrites && !w_stall
                                && (issueAddress != '0);
        w_issueRecord.address = RECORD_ADDR_WIDTH'(issueAddress);
        w_issueRecord.isLoad  = issueIsLoad;
    end

    // Destination record pipeline: every record moves one stage per clock.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k <= PIPE_DEPTH; k++) begin
                r_stages[k] <= EMPTY_RECORD;
            end
        end else begin
            r_stages[1] <= w_issueRecord;
            for (int k = 2; k <= PIPE_DEPTH; k++) begin
                r_stages[k] <= r_stages[k-1];
            end
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_port
        logic [RECORD_ADDR_WIDTH-1:0] w_portAddress;
        logic [DATA_WIDTH-1:0]        w_portData;
        logic [SEL_WIDTH-1:0]         w_portSelect;
        logic                         w_portHazard;

        assign w_portAddress = RECORD_ADDR_WIDTH'(readAddress[p*ADDR_WIDTH +: ADDR_WIDTH]);

        // Operand selection. Stages are scanned oldest to youngest so the
        // last hit, i.e. the smallest stage number, wins. A hit at the last
        // stage forwards stageData directly, covering the write that lands
        // in the array on this same edge.
        always_comb begin
            w_portSelect = SEL_WIDTH'(SEL_ARRAY);
            w_portData   = w_arrayData[p*DATA_WIDTH +: DATA_WIDTH];
            w_portHazard = 1'b0;
            if (w_portAddress == '0) begin
                w_portData = '0;
            end else begin
                for (int k = PIPE_DEPTH; k >= 1; k--) begin
                    if (recordMatches(r_stages[k], w_portAddress)) begin
                        w_portSelect = SEL_WIDTH'(k);
                        w_portData   = stageData[(k-1)*DATA_WIDTH +: DATA_WIDTH];
                        w_portHazard = r_stages[k].isLoad && (k < LOAD_READY_STAGE);
                    end
                end
            end
        end

        assign readData[p*DATA_WIDTH +: DATA_WIDTH]    = w_portData;
        assign forwardSelect[p*SEL_WIDTH +: SEL_WIDTH] = w_portSelect;
        assign w_loadHazard[p]                         = w_portHazard;
    end

    // A load whose data is not ready yet only matters to ports that use
    // their operand; whether decode is issuing this cycle is irrelevant.
    assign w_stall     = |(readEnable & w_loadHazard);
    assign shouldStall = w_stall;

    // Stalled-cycle counter, saturating at all-ones, cleared only by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_stallCount <= '0;
        end else if (w_stall && (r_stallCount != '1)) begin
            r_stallCount <= r_stallCount + 32'd1;
        end
    end

    assign stallCount = r_stallCount;

endmodule

// File: tb/tb_forwarding_register_file.sv
// ----------------------------------------------------------------------------
// tb_forwarding_register_file
//
// Purpose:
//   Self-checking bench for forwarding_register_file with default parameters.
//   A behavioural model (register array plus a queue of in-flight writes,
//   youngest first) predicts every output each cycle; directed steps add
//   fixed-value checks for the key scenarios, followed by a random phase.
// ----------------------------------------------------------------------------
module tb_forwarding_register_file;

    localparam int DW  = 32;
    localparam int AW  = 5;
    localparam int RP  = 2;
    localparam int PD  = 3;
    localparam int LRS = 2;
    localparam int SW  = $clog2(PD + 1);

    logic              clock;
    logic              reset;
    logic [RP*AW-1:0]  readAddress;
    logic [RP-1:0]     readEnable;
    logic [RP*DW-1:0]  readData;
    logic [RP*SW-1:0]  forwardSelect;
    logic              issueValid;
    logic              issueWrites;
    logic [AW-1:0]     issueAddress;
    logic              issueIsLoad;
    logic [PD*DW-1:0]  stageData;
    logic              shouldStall;
    logic [31:0]       stallCount;

    int compareCount = 0;
    int failCount    = 0;

    forwarding_register_file #(
        .DATA_WIDTH       (DW),
        .ADDR_WIDTH       (AW),
        .READ_PORTS       (RP),
        .PIPE_DEPTH       (PD),
        .LOAD_READY_STAGE (LRS)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .readAddress   (readAddress),
        .readEnable    (readEnable),
        .readData      (readData),
        .forwardSelect (forwardSelect),
        .issueValid    (issueValid),
        .issueWrites   (issueWrites),
        .issueAddress  (issueAddress),
        .issueIsLoad   (issueIsLoad),
        .stageData     (stageData),
        .shouldStall   (shouldStall),
        .stallCount    (stallCount)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit valid;
        int addr;
        bit isLoad;
    } flight_t;

    logic [DW-1:0] modelRegs [2**AW];
    flight_t       inFlight [$];
    logic [31:0]   modelCount;

    logic [DW-1:0] expData  [RP];
    int            expSel   [RP];
    bit            expStall;

    function automatic logic [DW-1:0] stageValue(input int k);
        return stageData[(k-1)*DW +: DW];
    endfunction

    task automatic modelClear();
        foreach (modelRegs[i]) modelRegs[i] = '0;
        inFlight.delete();
        for (int i = 0; i < PD; i++) inFlight.push_back('{valid: 0, addr: 0, isLoad: 0});
        modelCount = '0;
    endtask

    // inFlight[0] is the youngest write (stage 1), inFlight[PD-1] the oldest.
    task automatic computeExpected();
        expStall = 0;
        for (int p = 0; p < RP; p++) begin
            int a;
            bit found;
            a     = int'(readAddress[p*AW +: AW]);
            found = 0;
            expSel[p]  = 0;
            expData[p] = '0;
            if (a != 0) begin
                expData[p] = modelRegs[a];
                for (int i = 0; i < PD && !found; i++) begin
                    if (inFlight[i].valid && inFlight[i].addr == a) begin
                        found      = 1;
                        expSel[p]  = i + 1;
                        expData[p] = stageValue(i + 1);
                        if (readEnable[p] && inFlight[i].isLoad && (i + 1) < LRS) expStall = 1;
                    end
                end
            end
        end
    endtask

    task automatic modelStep();
        flight_t fresh;
        computeExpected();
        if (reset) begin
            modelClear();
        end else begin
            if (inFlight[PD-1].valid) modelRegs[inFlight[PD-1].addr] = stageValue(PD);
            void'(inFlight.pop_back());
            fresh.valid  = issueValid && issueWrites && !expStall && (issueAddress != 0);
            fresh.addr   = int'(issueAddress);
            fresh.isLoad = issueIsLoad;
            inFlight.push_front(fresh);
            if (expStall && modelCount != 32'hFFFF_FFFF) modelCount = modelCount + 1;
        end
    endtask

    // ---------------- stimulus / checking tasks ----------------
    task automatic applyStimulus(
        input bit             rst,
        input bit             iv,
        input bit             iw,
        input logic [AW-1:0]  ia,
        input bit             il,
        input logic [AW-1:0]  ra0,
        input logic [AW-1:0]  ra1,
        input logic [RP-1:0]  re,
        input logic [DW-1:0]  sd1,
        input logic [DW-1:0]  sd2,
        input logic [DW-1:0]  sd3
    );
        reset        = rst;
        issueValid   = iv;
        issueWrites  = iw;
        issueAddress = ia;
        issueIsLoad  = il;
        readAddress  = {ra1, ra0};
        readEnable   = re;
        stageData    = {sd3, sd2, sd1};
    endtask

    task automatic checkOutput();
        computeExpected();
        for (int p = 0; p < RP; p++) begin
            compareCount++;
            assert (readData[p*DW +: DW] === expData[p]) else begin
                failCount++;
                $error("FAIL readData%0d: observed %h expected %h", p, readData[p*DW +: DW], expData[p]);
            end
            compareCount++;
            assert (forwardSelect[p*SW +: SW] === SW'(expSel[p])) else begin
                failCount++;
                $error("FAIL forwardSelect%0d: observed %0d expected %0d", p, forwardSelect[p*SW +: SW], expSel[p]);
            end
        end
        compareCount++;
        assert (shouldStall === expStall) else begin
            failCount++;
            $error("FAIL shouldStall: observed %b expected %b", shouldStall, expStall);
        end
        compareCount++;
        assert (stallCount === modelCount) else begin
            failCount++;
            $error("FAIL stallCount: observed %0d expected %0d", stallCount, modelCount);
        end
    endtask

    task automatic checkConst(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
        compareCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic settle();
        @(negedge clock);
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clock);
        modelStep();
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        modelClear();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0);
        advance();
        advance();

        // put stale records in flight, then reset for two cycles
        applyStimulus(0, 1, 1, 5'd7, 1, 0, 0, 2'b00, 32'h77, 0, 0);
        advance();
        applyStimulus(0, 1, 1, 5'd8, 0, 0, 0, 2'b00, 0, 0, 0);
        advance();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 2'b00, 32'h1, 32'h2, 32'h3);
        advance();
        advance();

        // reset state: r7 reads 0 from the array
        applyStimulus(0, 0, 0, 0, 0, 5'd7, 5'd8, 2'b11, 32'hAAAA, 32'hBBBB, 32'hCCCC);
        settle();
        checkConst("reset_r7_data", readData[DW-1:0], 32'h0);
        checkConst("reset_r7_sel", DW'(forwardSelect[SW-1:0]), 32'd0);
        checkConst("reset_r8_data", readData[2*DW-1:DW], 32'h0);
        checkConst("reset_stall", DW'(shouldStall), 32'd0);
        checkConst("reset_count", stallCount, 32'd0);
        advance();

        // ALU forward from stage 1
        applyStimulus(0, 1, 1, 5'd3, 0, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd3, 0, 2'b01, 32'h1234, 0, 0);
        settle();
        checkConst("alu_fwd_data", readData[DW-1:0], 32'h1234);
        checkConst("alu_fwd_sel", DW'(forwardSelect[SW-1:0]), 32'd1);
        checkConst("alu_fwd_stall", DW'(shouldStall), 32'd0);
        advance();

        // load-use: stall at stage 1, forward from stage 2 a cycle later
        applyStimulus(0, 1, 1, 5'd4, 1, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(0, 1, 1, 5'd9, 0, 5'd4, 0, 2'b01, 32'h4444, 0, 0);
        settle();
        checkConst("load_use_stall", DW'(shouldStall), 32'd1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd4, 5'd9, 2'b11, 0, 32'hCAFE, 0);
        settle();
        checkConst("load_fwd_data", readData[DW-1:0], 32'hCAFE);
        checkConst("load_fwd_sel", DW'(forwardSelect[SW-1:0]), 32'd2);
        checkConst("load_fwd_stall", DW'(shouldStall), 32'd0);
        checkConst("load_fwd_count", stallCount, 32'd1);
        checkConst("bubble_r9_sel", DW'(forwardSelect[2*SW-1:SW]), 32'd0);
        advance();

        // priority: r5 at stages 1 and 3, then write-back of 0x55
        applyStimulus(0, 1, 1, 5'd5, 0, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(0, 1, 1, 5'd8, 0, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(0, 1, 1, 5'd5, 0, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd5, 2'b11, 32'h11, 32'h88, 32'h22);
        settle();
        checkConst("prio_data", readData[DW-1:0], 32'h11);
        checkConst("prio_sel", DW'(forwardSelect[SW-1:0]), 32'd1);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd8, 2'b11, 0, 32'h11, 32'h8888);
        settle();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd8, 2'b11, 0, 0, 32'h55);
        settle();
        checkConst("wt_data", readData[DW-1:0], 32'h55);
        checkConst("wt_sel", DW'(forwardSelect[SW-1:0]), 32'd3);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd5, 5'd8, 2'b11, 32'hDEAD, 32'hBEEF, 32'hF00D);
        settle();
        checkConst("wb_r5_data", readData[DW-1:0], 32'h55);
        checkConst("wb_r5_sel", DW'(forwardSelect[SW-1:0]), 32'd0);
        checkConst("wb_r8_data", readData[2*DW-1:DW], 32'h8888);
        advance();

        // register 0 is never tracked and never stalls
        applyStimulus(0, 1, 1, 5'd0, 1, 5'd0, 5'd0, 2'b11, 32'h99, 0, 0);
        settle();
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd0, 5'd0, 2'b11, 32'h99, 32'h98, 32'h97);
        settle();
        checkConst("r0_data", readData[DW-1:0], 32'h0);
        checkConst("r0_sel", DW'(forwardSelect[SW-1:0]), 32'd0);
        checkConst("r0_stall", DW'(shouldStall), 32'd0);
        advance();

        // reset mid-flight discards the pending load
        applyStimulus(0, 1, 1, 5'd6, 1, 0, 0, 2'b00, 0, 0, 0);
        settle();
        advance();
        applyStimulus(1, 0, 0, 0, 0, 5'd6, 0, 2'b01, 32'h66, 0, 0);
        advance();
        applyStimulus(0, 0, 0, 0, 0, 5'd6, 5'd5, 2'b11, 32'h66, 32'h66, 32'h66);
        settle();
        checkConst("midreset_stall", DW'(shouldStall), 32'd0);
        checkConst("midreset_data", readData[DW-1:0], 32'h0);
        checkConst("midreset_r5", readData[2*DW-1:DW], 32'h0);
        checkConst("midreset_count", stallCount, 32'd0);
        advance();

        // random phase against the model
        for (int n = 0; n < 600; n++) begin
            applyStimulus($urandom_range(0, 63) == 0,
                          $urandom_range(0, 3) != 0,
                          $urandom_range(0, 3) != 0,
                          AW'($urandom_range(0, 7)),
                          $urandom_range(0, 1) == 1,
                          AW'($urandom_range(0, 7)),
                          AW'($urandom_range(0, 7)),
                          RP'($urandom_range(0, 3)),
                          $urandom, $urandom, $urandom);
            settle();
            advance();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule

// File: doc/forwarding_register_file.md
Name: forwarding_register_file

Overview:
- Parametrised successor to the decode-stage register file.
- Integrates an N-read-port register array, an in-flight write tracker (shift pipeline of destination records, one per downstream stage), operand forwarding from any tracked stage, and load-use stall generation.
- Sits in decode: the issue side comes from the control unit, and stage result data comes from EX/MEM/WB.
- Register write-back is performed internally when a record retires from the last stage.

Parameters:
- DATA_WIDTH, 32, register/operand width.
- ADDR_WIDTH, 5, register address width; 2**ADDR_WIDTH registers.
- READ_PORTS, 2, number of independent read ports.
- PIPE_DEPTH, 3, number of tracked downstream stages (1=EX … PIPE_DEPTH=WB).
- LOAD_READY_STAGE, 2, first stage (1..PIPE_DEPTH) at which load data is valid.
- SEL_WIDTH, $clog2(PIPE_DEPTH+1), width of the forward select.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- readAddress  in  READ_PORTS*ADDR_WIDTH  per-port register address.
- readEnable  in  READ_PORTS  per-port operand used (gates stall).
- readData  out  READ_PORTS*DATA_WIDTH  per-port forwarded operand.
- forwardSelect  out  READ_PORTS*SEL_WIDTH  0 = array, k = stage k.
- issueValid  in  1  decode presents an instruction.
- issueWrites  in  1  instruction writes a register.
- issueAddress  in  ADDR_WIDTH  destination register.
- issueIsLoad  in  1  destination is produced by a load.
- stageData  in  PIPE_DEPTH*DATA_WIDTH  result currently held at stage k (slice k-1).
- shouldStall  out  1  hold PC/IF-ID, inject bubble.
- stallCount  out  32  saturating count of stalled cycles.

Behaviour:
- Clock and reset: single clock `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - All registers in the array are 0.
  - All records are invalid.
  - stallCount is 0.
  - shouldStall is 0 and readData is 0, since no records are pending and the array reads 0.
- Record: {valid, address, isLoad}, held in stages 1..PIPE_DEPTH.
- Each clock:
  - Stage k+1 ← stage k.
  - Stage 1 ← {issueValid & issueWrites & ~shouldStall & address≠0, issueAddress, issueIsLoad}.
  - When shouldStall=1, stage 1 receives an invalid record (bubble).
- Retirement: when stage PIPE_DEPTH holds a valid record, the array is written with address ← stageData[PIPE_DEPTH] at that edge.
- Reads, forwarding and stall are combinational, with zero latency.
- Per read port p:
  - If address=0: readData=0 and select=0. Register 0 never matches and never stalls.
  - Otherwise, find the smallest k whose valid record has a matching address.
    - If found: select=k and readData=stageData[k].
    - If none: select=0 and readData=array value.
  - The youngest match always wins, including over older matches and the array.
  - A match at stage PIPE_DEPTH forwards stageData (write-through), so the same-cycle write is seen.
- Stall:
  - shouldStall = OR over ports p with readEnable[p] of: matched record isLoad and k < LOAD_READY_STAGE.
  - The stall is independent of issueValid.
- stallCount increments each cycle that shouldStall=1 and saturates at 2^32-1. It is cleared only by reset.
- Reset mid-operation discards all pending records; their data is never written to the array.
- Address/data widths are exact. No sign handling is required.

Decomposition:
- Shared package holds:
  - DATA_WIDTH/ADDR_WIDTH defaults.
  - The record struct {valid, address, isLoad}.
  - The forward-select encoding constant SEL_ARRAY=0.
- Sub-module regfile_array:
  - Parametrised 2**ADDR_WIDTH × DATA_WIDTH array.
  - READ_PORTS asynchronous read ports and one synchronous write port.
  - Synchronous reset clear; register 0 is hard-wired to 0.
- The top level holds the record pipeline, the match/priority logic, the stall logic and the counter.

Test Plan:
- Reset: assert reset 2 cycles with stale records present → readData all 0, shouldStall 0, stallCount 0; reading r7 → 0, select 0.
- ALU forward: issue write r3 (not load). Next cycle set stageData[1]=0x1234 and read r3 on port 0 → readData0=0x1234, select=1, shouldStall=0.
- Load-use: issue load r4. Next cycle read r4 with readEnable → shouldStall=1 and a bubble enters stage 1. Following cycle set stageData[2]=0xCAFE → readData=0xCAFE, select=2, shouldStall=0, stallCount=1.
- Priority and write-back:
  - r5 at stage 1 (0x11) and stage 3 (0x22) → read 0x11.
  - After the stage-3 record retires with 0x55 and no newer match exists → read 0x55, select 0.
- Register 0: issue write r0 (load), then read r0 with readEnable → readData=0, shouldStall=0, and no record is created.
- Reset mid-flight: load r6 pending at stage 1, assert reset one cycle, then read r6 → shouldStall=0 and readData=0.
